// File: rtl/pc_if.sv
// Fetch-stage PC unit signal bundle: control requests in, PC/mepc/status out.
interface pc_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) ();
  logic             stall;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_target;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_epc;
  logic [XLEN-1:0]  trap_vector;
  logic             mret_valid;
  logic             retire;
  logic [XLEN-1:0]  current_PC;
  logic [XLEN-1:0]  mepc;
  logic             flush;
  logic             misaligned;
  logic [XLEN-1:0]  misaligned_addr;
  logic [CNT_W-1:0] instret;

  modport master (
    output stall, redirect_valid, redirect_target, trap_valid, trap_epc,
           trap_vector, mret_valid, retire,
    input  current_PC, mepc, flush, misaligned, misaligned_addr, instret
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_valid, trap_epc,
           trap_vector, mret_valid, retire,
    output current_PC, mepc, flush, misaligned, misaligned_addr, instret
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC priority select, mepc ownership,
// misaligned-target fault detection and retired-instruction counter.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
  parameter int unsigned     IALIGN       = 4,
  parameter int unsigned     CNT_W        = 64
) (
  input logic  clk,
  input logic  rst,
  pc_if.slave  bus
);

  // Clears the low log2(IALIGN) bits of an address.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(IALIGN - 1);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_mepc;
  logic             r_flush;
  logic             r_misaligned;
  logic [XLEN-1:0]  r_misaligned_addr;
  logic [CNT_W-1:0] r_instret;

  logic [XLEN-1:0]  w_tv_al;
  logic             w_target_misaligned;

  assign w_tv_al             = bus.trap_vector & ALIGN_MASK;
  assign w_target_misaligned = |(bus.redirect_target & ~ALIGN_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc              <= BOOT_ADDRESS;
      r_mepc            <= '0;
      r_flush           <= 1'b0;
      r_misaligned      <= 1'b0;
      r_misaligned_addr <= '0;
    end else begin
      r_flush      <= 1'b0;
      r_misaligned <= 1'b0;
      if (bus.trap_valid) begin
        r_pc    <= w_tv_al;
        r_mepc  <= bus.trap_epc & ALIGN_MASK;
        r_flush <= 1'b1;
      end else if (bus.mret_valid) begin
        r_pc    <= r_mepc;
        r_flush <= 1'b1;
      end else if (bus.redirect_valid && w_target_misaligned) begin
        // Faulting redirect: the current PC becomes the exception PC.
        r_pc              <= w_tv_al;
        r_mepc            <= r_pc;
        r_misaligned      <= 1'b1;
        r_misaligned_addr <= bus.redirect_target;
        r_flush           <= 1'b1;
      end else if (bus.redirect_valid) begin
        r_pc    <= bus.redirect_target;
        r_flush <= 1'b1;
      end else if (!bus.stall) begin
        r_pc <= r_pc + XLEN'(IALIGN);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
    end else if (bus.retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign bus.current_PC      = r_pc;
  assign bus.mepc            = r_mepc;
  assign bus.flush           = r_flush;
  assign bus.misaligned      = r_misaligned;
  assign bus.misaligned_addr = r_misaligned_addr;
  assign bus.instret         = r_instret;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed vectors push expected state,
// a monitor pops and compares one entry after every clock edge.
module tb_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        fl;
    logic        mis;
    logic [31:0] ma;
    logic [31:0] mepc;
    logic [7:0]  ir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] m_ir = 8'h00;

  pc_if #(.XLEN(32), .CNT_W(8)) bus ();

  pc_unit #(
    .XLEN(32),
    .BOOT_ADDRESS(32'h0000_0000),
    .IALIGN(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents new state after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", bus.current_PC, e.pc);
      chk("flush", {31'b0, bus.flush}, {31'b0, e.fl});
      chk("misaligned", {31'b0, bus.misaligned}, {31'b0, e.mis});
      chk("misaligned_addr", bus.misaligned_addr, e.ma);
      chk("mepc", bus.mepc, e.mepc);
      chk("instret", {24'b0, bus.instret}, {24'b0, e.ir});
    end
  end

  // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge.
  task automatic step(input logic st, input logic rv, input logic [31:0] rt,
                      input logic tr, input logic [31:0] epc, input logic mr,
                      input logic ret, input logic [31:0] e_pc, input logic e_fl,
                      input logic e_mis, input logic [31:0] e_ma, input logic [31:0] e_mepc);
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.trap_valid      = tr;
    bus.trap_epc        = epc;
    bus.trap_vector     = 32'h0000_0203;
    bus.mret_valid      = mr;
    bus.retire          = ret;
    if (ret) m_ir = m_ir + 8'd1;
    q.push_back('{pc: e_pc, fl: e_fl, mis: e_mis, ma: e_ma, mepc: e_mepc, ir: m_ir});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
    bus.trap_valid = 1'b0; bus.trap_epc = '0; bus.trap_vector = 32'h203;
    bus.mret_valid = 1'b0; bus.retire = 1'b0;

    #2;
    chk("reset_pc", bus.current_PC, 32'h0);
    chk("reset_instret", {24'b0, bus.instret}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //   st rv  target        tr epc           mr ret  pc            fl mis ma           mepc
    step(0, 0, 32'h0,         0, 32'h0,        0, 0,  32'h0000_0004, 0, 0, 32'h0,       32'h0);
    step(0, 0, 32'h0,         0, 32'h0,        0, 1,  32'h0000_0008, 0, 0, 32'h0,       32'h0);
    step(1, 1, 32'h100,       0, 32'h0,        0, 0,  32'h0000_0100, 1, 0, 32'h0,       32'h0);
    step(0, 0, 32'h0,         0, 32'h0,        0, 1,  32'h0000_0104, 0, 0, 32'h0,       32'h0);
    step(1, 0, 32'h0,         0, 32'h0,        0, 0,  32'h0000_0104, 0, 0, 32'h0,       32'h0);
    step(0, 1, 32'h102,       0, 32'h0,        0, 0,  32'h0000_0200, 1, 1, 32'h102,     32'h104);
    step(0, 0, 32'h0,         0, 32'h0,        0, 0,  32'h0000_0204, 0, 0, 32'h102,     32'h104);
    step(0, 0, 32'h0,         1, 32'h44,       0, 1,  32'h0000_0200, 1, 0, 32'h102,     32'h44);
    step(0, 0, 32'h0,         0, 32'h0,        1, 0,  32'h0000_0044, 1, 0, 32'h102,     32'h44);
    step(0, 0, 32'h0,         0, 32'h0,        0, 1,  32'h0000_0048, 0, 0, 32'h102,     32'h44);
    step(0, 1, 32'h301,       1, 32'h4B,       1, 0,  32'h0000_0200, 1, 0, 32'h102,     32'h48);
    step(0, 1, 32'h300,       0, 32'h0,        0, 0,  32'h0000_0300, 1, 0, 32'h102,     32'h48);
    step(1, 1, 32'h400,       0, 32'h0,        0, 1,  32'h0000_0400, 1, 0, 32'h102,     32'h48);
    step(0, 0, 32'h0,         0, 32'h0,        1, 0,  32'h0000_0048, 1, 0, 32'h102,     32'h48);
    step(1, 0, 32'h0,         0, 32'h0,        0, 1,  32'h0000_0048, 0, 0, 32'h102,     32'h48);
    step(0, 1, 32'hFFFF_FFFC, 0, 32'h0,        0, 0,  32'hFFFF_FFFC, 1, 0, 32'h102,     32'h48);
    step(0, 0, 32'h0,         0, 32'h0,        0, 0,  32'h0000_0000, 0, 0, 32'h102,     32'h48);
    step(0, 0, 32'h0,         0, 32'h0,        0, 0,  32'h0000_0004, 0, 0, 32'h102,     32'h48);

    // Hold retire high long enough for the 8-bit counter to pass 0xFF -> 0x00.
    for (int i = 0; i < 260; i++) begin
      step(0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h8 + 32'(i) * 32'd4, 0, 0, 32'h102, 32'h48);
    end

    // Asynchronous reset mid-cycle with requests pending.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_pc", bus.current_PC, 32'h0);
    chk("async_mepc", bus.mepc, 32'h0);
    chk("async_instret", {24'b0, bus.instret}, 32'h0);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h100;
    bus.trap_valid = 1'b1; bus.retire = 1'b1;
    @(posedge clk);
    #1;
    chk("held_pc", bus.current_PC, 32'h0);
    chk("held_flush", {31'b0, bus.flush}, 32'h0);
    chk("held_maddr", bus.misaligned_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_ir = 8'h00;
    step(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h4, 0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h8, 0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'hC, 0, 0, 32'h0, 32'h0);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
